// File: rtl/window_pkg.sv
// Shared types and elaboration helpers for the sliding-window generator.
package window_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } win_state_e;

    // Counter width for a range of n values, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bit offset of window element (r,c) in the packed K x K window.
    function automatic int elem_off(input int r, input int c, input int k, input int dw);
        return (r * k + c) * dw;
    endfunction

endpackage

// File: rtl/window_gen_line_buffer.sv
// One image line of storage with a registered read port.
// The array has no reset, so synthesis can map it to block or distributed RAM.
module line_buffer
    import window_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 540
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [cnt_w(IMG_W)-1:0] wr_addr,
    input  logic [cnt_w(IMG_W)-1:0] rd_addr,
    input  logic [DW-1:0]           din,
    output logic [DW-1:0]           dout
);

    logic [DW-1:0] mem [IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
        dout <= mem[rd_addr];
    end

endmodule

// File: rtl/window_gen.sv
// Sliding K x K window generator over a raster pixel stream, buffering K-1 lines.
// Emits one window per accepted pixel once K rows and K columns are available.
module window_gen
    import window_pkg::*;
#(
    parameter int DW    = 8,
    parameter int IMG_W = 540,
    parameter int IMG_H = 360,
    parameter int K     = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    core_run_i,
    input  logic [DW-1:0]           data_i,
    input  logic                    data_en_i,
    output logic [K*K*DW-1:0]       win_o,
    output logic                    win_en_o,
    output logic [cnt_w(IMG_H)-1:0] win_row_o,
    output logic [cnt_w(IMG_W)-1:0] win_col_o,
    output logic                    busy_o,
    output logic                    core_done_o,
    output logic                    drop_o
);

    localparam int CW = cnt_w(IMG_W);
    localparam int RW = cnt_w(IMG_H);
    localparam int WW = K * K * DW;

    win_state_e      state_reg, state_next;
    logic [CW-1:0]   col_reg, col_next;
    logic [RW-1:0]   row_reg, row_next;
    logic            accept;
    logic            win_valid;
    logic [WW-1:0]   shift_reg, shift_next;
    logic [K*DW-1:0] col_in;
    logic [DW-1:0]   lb_dout [K-1];

    logic [WW-1:0]   win_reg;
    logic            win_en_reg;
    logic [RW-1:0]   win_row_reg;
    logic [CW-1:0]   win_col_reg;
    logic            drop_reg;

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        row_next   = row_reg;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (core_run_i) begin
                    state_next = RUN;
                    col_next   = '0;
                    row_next   = '0;
                end
            end
            RUN: begin
                if (data_en_i) begin
                    accept = 1'b1;
                    if (col_reg == CW'(IMG_W - 1)) begin
                        col_next = '0;
                        if (row_reg == RW'(IMG_H - 1)) begin
                            row_next   = '0;
                            state_next = DONE;
                        end else begin
                            row_next = row_reg + 1'b1;
                        end
                    end else begin
                        col_next = col_reg + 1'b1;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign win_valid = accept && (row_reg >= RW'(K - 1)) && (col_reg >= CW'(K - 1));

    // Newest line enters the bottom row; each buffer output feeds the row above.
    assign col_in[(K-1)*DW +: DW] = data_i;

    genvar gi;
    generate
        for (gi = 0; gi < K - 1; gi++) begin : g_lb
            logic [DW-1:0] lb_din;
            if (gi == 0) begin : g_first
                assign lb_din = data_i;
            end else begin : g_chain
                assign lb_din = lb_dout[gi-1];
            end

            // Read address runs on col_next so the pixel one line up at the
            // upcoming column is already registered when that pixel arrives.
            line_buffer #(
                .DW    (DW),
                .IMG_W (IMG_W)
            ) u_lb (
                .clk     (clk),
                .wr_en   (accept),
                .wr_addr (col_reg),
                .rd_addr (col_next),
                .din     (lb_din),
                .dout    (lb_dout[gi])
            );

            assign col_in[(K-2-gi)*DW +: DW] = lb_dout[gi];
        end
    endgenerate

    always_comb begin
        shift_next = shift_reg;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                shift_next[elem_off(r, c, K, DW) +: DW] = shift_reg[elem_off(r, c + 1, K, DW) +: DW];
            end
            shift_next[elem_off(r, K - 1, K, DW) +: DW] = col_in[r*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            col_reg     <= '0;
            row_reg     <= '0;
            shift_reg   <= '0;
            win_reg     <= '0;
            win_en_reg  <= 1'b0;
            win_row_reg <= '0;
            win_col_reg <= '0;
            drop_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            col_reg    <= col_next;
            row_reg    <= row_next;
            win_en_reg <= win_valid;
            drop_reg   <= data_en_i && (state_reg != RUN);
            if (accept) begin
                shift_reg <= shift_next;
            end
            if (win_valid) begin
                win_reg     <= shift_next;
                win_row_reg <= row_reg - RW'(K - 1);
                win_col_reg <= col_reg - CW'(K - 1);
            end
        end
    end

    assign win_o       = win_reg;
    assign win_en_o    = win_en_reg;
    assign win_row_o   = win_row_reg;
    assign win_col_o   = win_col_reg;
    assign busy_o      = (state_reg != IDLE);
    assign core_done_o = (state_reg == DONE);
    assign drop_o      = drop_reg;

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen: 6x5 K=3 and 8x6 K=5 instances fed with ramp frames.
module tb_window_gen;

    typedef struct {
        int row;
        int col;
        bit done;
    } exp_t;

    typedef struct {
        int           row;
        int           col;
        logic [199:0] win;
        bit           done;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run3, en3, run5, en5;
    logic [7:0]  data3, data5;

    logic [71:0]  win3;
    logic         win_en3, busy3, done3, drop3;
    logic [2:0]   win_row3, win_col3;
    logic [199:0] win5;
    logic         win_en5, busy5, done5, drop5;
    logic [2:0]   win_row5, win_col5;

    int   n_chk = 0;
    int   n_pass = 0;
    int   done3_cnt = 0;
    int   drop3_cnt = 0;
    int   spurious3 = 0;
    logic en3_edge = 1'b0;
    rec_t q3[$];
    rec_t q5[$];
    exp_t exp3 [12];
    exp_t exp5 [8];

    always #5 clk = ~clk;

    window_gen #(.DW(8), .IMG_W(6), .IMG_H(5), .K(3)) dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_run_i  (run3),
        .data_i      (data3),
        .data_en_i   (en3),
        .win_o       (win3),
        .win_en_o    (win_en3),
        .win_row_o   (win_row3),
        .win_col_o   (win_col3),
        .busy_o      (busy3),
        .core_done_o (done3),
        .drop_o      (drop3)
    );

    window_gen #(.DW(8), .IMG_W(8), .IMG_H(6), .K(5)) dut5 (
        .clk         (clk),
        .rst_n       (rst_n),
        .core_run_i  (run5),
        .data_i      (data5),
        .data_en_i   (en5),
        .win_o       (win5),
        .win_en_o    (win_en5),
        .win_row_o   (win_row5),
        .win_col_o   (win_col5),
        .busy_o      (busy5),
        .core_done_o (done5),
        .drop_o      (drop5)
    );

    always @(posedge clk) en3_edge <= en3;

    always @(negedge clk) begin
        rec_t rr;
        if (win_en3) begin
            rr.row  = int'(win_row3);
            rr.col  = int'(win_col3);
            rr.win  = 200'(win3);
            rr.done = done3;
            q3.push_back(rr);
            if (!en3_edge) spurious3++;
        end
        if (win_en5) begin
            rr.row  = int'(win_row5);
            rr.col  = int'(win_col5);
            rr.win  = win5;
            rr.done = done5;
            q5.push_back(rr);
        end
        if (done3) done3_cnt++;
        if (drop3) drop3_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_vec(input string name, input logic [199:0] act, input logic [199:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [199:0] ramp_win(input int r0, input int c0, input int k);
        logic [199:0] v = '0;
        for (int r = 0; r < k; r++)
            for (int c = 0; c < k; c++)
                v[(r*k+c)*8 +: 8] = 8'((r0 + r) * 16 + c0 + c);
        return v;
    endfunction

    // Ramp frame into dut3; optional random gaps, a core_run pulse at pixel run_at,
    // and an early stop after stop_after pixels (-1 = whole frame).
    task automatic frame3(input int max_gap, input int run_at, input int stop_after);
        int idx = 0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 6; c++) begin
                if (idx == stop_after) return;
                data3 = 8'(r * 16 + c);
                en3   = 1'b1;
                run3  = (idx == run_at);
                step();
                en3  = 1'b0;
                run3 = 1'b0;
                if (max_gap > 0) repeat ($urandom_range(max_gap, 0)) step();
                idx++;
            end
        end
    endtask

    task automatic start3();
        run3 = 1'b1;
        step();
        run3 = 1'b0;
    endtask

    task automatic check_frame3(input string tag);
        chk_int({tag, "_count"}, q3.size(), 12);
        for (int i = 0; i < 12 && i < q3.size(); i++) begin
            chk_int($sformatf("%s_row%0d", tag, i), q3[i].row, exp3[i].row);
            chk_int($sformatf("%s_col%0d", tag, i), q3[i].col, exp3[i].col);
            chk_vec($sformatf("%s_win%0d", tag, i), q3[i].win, ramp_win(exp3[i].row, exp3[i].col, 3));
            chk_int($sformatf("%s_done%0d", tag, i), int'(q3[i].done), int'(exp3[i].done));
        end
        $display("frame %s: %0d windows observed", tag, q3.size());
    endtask

    initial begin
        exp3 = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 2, 0}, '{0, 3, 0},
                 '{1, 0, 0}, '{1, 1, 0}, '{1, 2, 0}, '{1, 3, 0},
                 '{2, 0, 0}, '{2, 1, 0}, '{2, 2, 0}, '{2, 3, 1}};
        exp5 = '{'{0, 0, 0}, '{0, 1, 0}, '{0, 2, 0}, '{0, 3, 0},
                 '{1, 0, 0}, '{1, 1, 0}, '{1, 2, 0}, '{1, 3, 1}};

        rst_n = 1'b0;
        run3 = 1'b0; en3 = 1'b0; data3 = '0;
        run5 = 1'b0; en5 = 1'b0; data5 = '0;
        repeat (3) step();
        @(negedge clk);
        chk_vec("reset_out3", 200'({win3, win_en3, win_row3, win_col3, busy3, done3, drop3}), 200'd0);
        chk_vec("reset_out5", {win5, win_en5, win_row5, win_col5, busy5, done5, drop5} >> 0, 200'd0);
        step();
        rst_n = 1'b1;
        step();

        // Pixels while IDLE are dropped.
        for (int i = 0; i < 3; i++) begin
            data3 = 8'(8'hA0 + i);
            en3   = 1'b1;
            step();
            en3   = 1'b0;
            step();
        end
        step();
        chk_int("idle_drops", drop3_cnt, 3);
        chk_int("idle_busy", int'(busy3), 0);
        chk_int("idle_no_win", q3.size(), 0);

        // Contiguous frame with an ignored core_run pulse mid-frame.
        start3();
        chk_int("run_busy", int'(busy3), 1);
        done3_cnt = 0;
        drop3_cnt = 0;
        frame3(0, 10, -1);
        step(); step();
        check_frame3("contig");
        if (q3.size() > 0) begin
            chk_vec("first_e00", 200'(q3[0].win[7:0]), 200'h00);
            chk_vec("first_e11", 200'(q3[0].win[39:32]), 200'h11);
            chk_vec("first_e22", 200'(q3[0].win[71:64]), 200'h22);
        end
        chk_int("contig_done_cnt", done3_cnt, 1);
        chk_int("contig_drops", drop3_cnt, 0);
        chk_int("contig_busy_after", int'(busy3), 0);

        // Same frame with random gaps.
        q3.delete();
        spurious3 = 0;
        start3();
        frame3(5, -1, -1);
        step(); step();
        check_frame3("gaps");
        chk_int("gaps_spurious", spurious3, 0);

        // Reset after 17 pixels, then a clean frame.
        start3();
        frame3(0, -1, 17);
        rst_n = 1'b0;
        @(negedge clk);
        chk_vec("midrst_out3", 200'({win3, win_en3, win_row3, win_col3, busy3, done3, drop3}), 200'd0);
        step();
        rst_n = 1'b1;
        step();
        q3.delete();
        done3_cnt = 0;
        start3();
        frame3(0, -1, -1);
        step(); step();
        check_frame3("post_rst");
        chk_int("post_rst_done_cnt", done3_cnt, 1);

        // Back-to-back frames: core_run one cycle after core_done.
        q3.delete();
        start3();
        frame3(0, -1, -1);
        step();
        check_frame3("b2b_first");
        q3.delete();
        start3();
        frame3(0, -1, -1);
        step(); step();
        check_frame3("b2b_second");

        // K=5 frame.
        run5 = 1'b1;
        step();
        run5 = 1'b0;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 8; c++) begin
                data5 = 8'(r * 16 + c);
                en5   = 1'b1;
                step();
                en5   = 1'b0;
            end
        end
        step(); step();
        chk_int("k5_count", q5.size(), 8);
        for (int i = 0; i < 8 && i < q5.size(); i++) begin
            chk_int($sformatf("k5_row%0d", i), q5[i].row, exp5[i].row);
            chk_int($sformatf("k5_col%0d", i), q5[i].col, exp5[i].col);
            chk_vec($sformatf("k5_win%0d", i), q5[i].win, ramp_win(exp5[i].row, exp5[i].col, 5));
            chk_int($sformatf("k5_done%0d", i), int'(q5[i].done), int'(exp5[i].done));
        end
        if (q5.size() >= 8) begin
            chk_vec("k5_last_e44", 200'(q5[7].win[199:192]), 200'h57);
        end
        $display("frame k5: %0d windows observed", q5.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
